// File: rtl/int_to_bcd_serial_pkg.sv
// Shared constants and state type for the serial signed-integer to BCD converter.
package int_to_bcd_serial_pkg;

  localparam int unsigned IN_W_DEF   = 64;
  localparam int unsigned DIGITS_DEF = 19;
  localparam int unsigned DIG_W      = 4;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/int_to_bcd_serial_dabble_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_dabble_digit
  import int_to_bcd_serial_pkg::*;
(
  input  logic [DIG_W-1:0] d,
  output logic [DIG_W-1:0] q
);

  // No carry out: the following shift moves the overflow into the next digit.
  always_comb begin
    q = d;
    if (d >= DIG_W'(5)) begin
      q = d + DIG_W'(3);
    end
  end

endmodule

// File: rtl/int_to_bcd_serial.sv
// Iterative double-dabble: converts a signed integer to sign + BCD magnitude, one bit per clock.
module int_to_bcd_serial
  import int_to_bcd_serial_pkg::*;
#(
  parameter int unsigned IN_W   = IN_W_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         int_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_neg,
  output logic [DIG_W*DIGITS-1:0] out_bcd,
  output logic [4:0]              out_ndig
);

  localparam int unsigned CntW = $clog2(IN_W);
  localparam int unsigned BcdW = DIG_W * DIGITS;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   mag_q;
  logic [BcdW-1:0]   bcd_q;
  logic [BcdW-1:0]   bcd_corr;
  logic [CntW-1:0]   cnt_q;
  logic              neg_q;
  logic [IN_W-1:0]   in_mag;
  logic              last_step;
  logic [4:0]        ndig;

  // The most negative value wraps onto itself and is read as unsigned 2^(IN_W-1).
  assign in_mag    = int_in[IN_W-1] ? (~int_in + 1'b1) : int_in;
  assign last_step = (cnt_q == CntW'(IN_W - 1));

  for (genvar g = 0; g < DIGITS; g++) begin : gen_digit
    bcd_dabble_digit u_digit (
      .d (bcd_q[DIG_W*g +: DIG_W]),
      .q (bcd_corr[DIG_W*g +: DIG_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)  state_d = StShift;
      StShift: if (last_step) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q <= '0;
      bcd_q <= '0;
      neg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            mag_q <= in_mag;
            neg_q <= int_in[IN_W-1];
            bcd_q <= '0;
            cnt_q <= '0;
          end
        end
        StShift: begin
          bcd_q <= {bcd_corr[BcdW-2:0], mag_q[IN_W-1]};
          mag_q <= {mag_q[IN_W-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Significant-digit count: highest nonzero digit index + 1, never below 1.
  always_comb begin
    ndig = 5'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[DIG_W*i +: DIG_W] != '0) begin
        ndig = 5'(i + 1);
      end
    end
  end

  assign out_neg  = neg_q;
  assign out_bcd  = bcd_q;
  assign out_ndig = ndig;

endmodule
